// File: rtl/hls_slave_pkg.sv
// Shared types for the slave-RAM initiator.
//  op_e     : host command opcodes (value 3 is accepted and discarded)
//  status_e : response status codes
//  state_e  : sequencer states
//  LANES    : number of lanes on every S_* bus (only lane 0 is ever driven)
//  CNT_W    : width of the run cycle counter (zero-extended onto rsp_data)
package hls_slave_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RUN   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    RSP_OK         = 2'd0,
    RSP_RD_TIMEOUT = 2'd1,
    RSP_RUN_LIMIT  = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_START,
    ST_RUN,
    ST_RESP
  } state_e;

  localparam int unsigned LANES = 2;
  localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/hls_run_counter.sv
// Run cycle counter for the initiator.
//  clock, reset : clock, async active-low reset (count returns to 0)
//  clear        : load 1 (the start cycle counts as the first run cycle)
//  enable       : add 1, saturating at all-ones
//  count_next   : value the counter takes at the next edge, i.e. the count
//                 including the current cycle
//  limit_hit    : count_next has reached LIMIT
module hls_run_counter #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned LIMIT = 200000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count_next,
  output logic             limit_hit
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_q;

  // NOTE: every signal written here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count_q;
    if (clear) begin
      count_next = CNT_W'(1);
    end else if (enable && (count_q != '1)) begin
      count_next = count_q + 1'b1;
    end
  end

  assign limit_hit = (count_next >= LIMIT_V);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

endmodule

// File: rtl/hls_slave_mem_initiator.sv
// Host-side initiator for the accelerator's slave RAM port and start/done pair.
// Host commands (WRITE / READ / RUN) are sequenced onto lane 0 of the slave
// bus; each command except the reserved opcode produces one response pulse.
//  clock, reset           : clock, async active-low reset
//  cmd_valid/cmd_ready    : command handshake (ready only in IDLE)
//  cmd_op/addr/size/wdata : opcode, byte address, access size in bits, data
//  rsp_valid/status/data  : one-cycle response, status, read data or count
//  start_port, done_port  : run handshake with the core
//  S_oe_ram .. S_data_ram_size : registered slave-bus drive, lane 1 tied 0
//  Sout_Rdata_ram, Sout_DataRdy : slave read return, lane 0 only
module hls_slave_mem_initiator
  import hls_slave_pkg::*;
#(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned SIZE_W     = 7,
  parameter int unsigned RD_TIMEOUT = 16,
  parameter int unsigned RUN_LIMIT  = 200000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [SIZE_W-1:0]         cmd_size,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  output logic [1:0]                rsp_status,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      start_port,
  input  logic                      done_port,
  output logic [LANES-1:0]          S_oe_ram,
  output logic [LANES-1:0]          S_we_ram,
  output logic [LANES*ADDR_W-1:0]   S_addr_ram,
  output logic [LANES*DATA_W-1:0]   S_Wdata_ram,
  output logic [LANES*SIZE_W-1:0]   S_data_ram_size,
  input  logic [LANES*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [LANES-1:0]          Sout_DataRdy
);

  localparam int unsigned WAIT_W = $clog2(RD_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                oe_q, oe_d;
  logic                we_q, we_d;
  logic                start_q, start_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  status_e             rsp_status_q, rsp_status_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic                cnt_clear, cnt_en, limit_hit;
  logic [CNT_W-1:0]    run_count;
  logic [DATA_W-1:0]   rdata_masked;

  // Lane 1 of the read return is never consumed.
  logic unused_lane1;
  assign unused_lane1 = ^{Sout_Rdata_ram[LANES*DATA_W-1:DATA_W], Sout_DataRdy[LANES-1:1]};

  // Keep only the low cmd_size bits of a read; sizes of DATA_W or more pass
  // the whole lane.
  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
    logic [DATA_W-1:0] one;
    one = DATA_W'(1);
    if (32'(size) >= DATA_W) size_mask = '1;
    else                     size_mask = (one << size) - one;
  endfunction

  assign rdata_masked = Sout_Rdata_ram[DATA_W-1:0] & size_mask(size_q);

  hls_run_counter #(
    .CNT_W (CNT_W),
    .LIMIT (RUN_LIMIT)
  ) u_run_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear),
    .enable     (cnt_en),
    .count_next (run_count),
    .limit_hit  (limit_hit)
  );

  // Every bus/port output is the registered image of its *_d value, so a
  // strobe computed on the transition into a state is visible for exactly
  // the cycle spent in that state.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wait_d       = wait_q;
    oe_d         = 1'b0;
    we_d         = 1'b0;
    start_d      = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          addr_d  = cmd_addr;
          size_d  = cmd_size;
          wdata_d = cmd_wdata;
          case (op_e'(cmd_op))
            OP_WRITE: begin state_d = ST_WR;       we_d    = 1'b1; end
            OP_READ:  begin state_d = ST_RD_ISSUE; oe_d    = 1'b1; end
            OP_RUN:   begin state_d = ST_START;    start_d = 1'b1; end
            default:  state_d = ST_IDLE;  // reserved opcode: consumed, no response
          endcase
        end
      end

      ST_WR: begin
        state_d      = ST_RESP;
        rsp_valid_d  = 1'b1;
        rsp_status_d = RSP_OK;
        rsp_data_d   = '0;
      end

      ST_RD_ISSUE: begin
        wait_d = '0;
        if (Sout_DataRdy[0]) begin
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_OK;
          rsp_data_d   = rdata_masked;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (Sout_DataRdy[0]) begin
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_OK;
          rsp_data_d   = rdata_masked;
        end else if (wait_q == WAIT_W'(RD_TIMEOUT - 1)) begin
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_RD_TIMEOUT;
          rsp_data_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      // START and RUN share the completion rules; done wins over the limit
      // when both land in the same cycle.
      ST_START, ST_RUN: begin
        cnt_clear = (state_q == ST_START);
        cnt_en    = (state_q == ST_RUN);
        if (done_port || limit_hit) begin
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = done_port ? RSP_OK : RSP_RUN_LIMIT;
          rsp_data_d   = DATA_W'(run_count);
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wait_q       <= '0;
      oe_q         <= 1'b0;
      we_q         <= 1'b0;
      start_q      <= 1'b0;
      ready_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= RSP_OK;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wait_q       <= wait_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      start_q      <= start_d;
      ready_q      <= ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign cmd_ready       = ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_status      = rsp_status_q;
  assign rsp_data        = rsp_data_q;
  assign start_port      = start_q;
  assign S_oe_ram        = {1'b0, oe_q};
  assign S_we_ram        = {1'b0, we_q};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
  assign S_Wdata_ram     = {{DATA_W{1'b0}}, wdata_q};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, size_q};

endmodule

// File: tb/tb_hls_slave_mem_initiator.sv
// Self-checking bench for hls_slave_mem_initiator. Two instances share all
// inputs: u_dut with the default run limit and u_lim with RUN_LIMIT=50.
// A slave-RAM / core responder model sits on u_dut's bus; expectations come
// from a reference memory updated per host command and the command rules.
module tb_hls_slave_mem_initiator;

  localparam int RD_TO   = 16;
  localparam int B_LIMIT = 50;
  localparam logic [1:0] OPW = 2'd0, OPR = 2'd1, OPN = 2'd2, OPX = 2'd3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = '0;
  logic [8:0]   cmd_addr = '0;
  logic [6:0]   cmd_size = '0;
  logic [63:0]  cmd_wdata = '0;
  logic         done_port = 1'b0;
  logic [127:0] sout_rdata = '0;
  logic [1:0]   sout_rdy = '0;

  logic a_ready, a_rsp_valid, a_start;
  logic [1:0] a_rsp_status, a_oe, a_we;
  logic [63:0] a_rsp_data;
  logic [17:0] a_addr;
  logic [127:0] a_wdata;
  logic [13:0] a_size;

  logic b_ready, b_rsp_valid, b_start;
  logic [1:0] b_rsp_status, b_oe, b_we;
  logic [63:0] b_rsp_data;
  logic [17:0] b_addr;
  logic [127:0] b_wdata;
  logic [13:0] b_size;

  hls_slave_mem_initiator #(
    .ADDR_W(9), .DATA_W(64), .SIZE_W(7), .RD_TIMEOUT(RD_TO), .RUN_LIMIT(200000000)
  ) u_dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(a_rsp_valid), .rsp_status(a_rsp_status), .rsp_data(a_rsp_data),
    .start_port(a_start), .done_port(done_port),
    .S_oe_ram(a_oe), .S_we_ram(a_we), .S_addr_ram(a_addr), .S_Wdata_ram(a_wdata),
    .S_data_ram_size(a_size), .Sout_Rdata_ram(sout_rdata), .Sout_DataRdy(sout_rdy)
  );

  hls_slave_mem_initiator #(
    .ADDR_W(9), .DATA_W(64), .SIZE_W(7), .RD_TIMEOUT(RD_TO), .RUN_LIMIT(B_LIMIT)
  ) u_lim (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_status(b_rsp_status), .rsp_data(b_rsp_data),
    .start_port(b_start), .done_port(done_port),
    .S_oe_ram(b_oe), .S_we_ram(b_we), .S_addr_ram(b_addr), .S_Wdata_ram(b_wdata),
    .S_data_ram_size(b_size), .Sout_Rdata_ram(sout_rdata), .Sout_DataRdy(sout_rdy)
  );

  initial forever #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] size_mask(input int s);
    if (s >= 64) return '1;
    return (64'd1 << s) - 64'd1;
  endfunction

  // Slave RAM contents as seen on the bus, and the host's view of it.
  logic [63:0] mem     [logic [8:0]];
  logic [63:0] ref_mem [logic [8:0]];

  int resp_lat = 0;     // DataRdy delay after oe, -1 = never
  int done_after = -1;  // done delay after start pulse, -1 = never
  int rd_cnt = -1, done_cnt = -1;
  logic [8:0] rd_addr = '0;
  int we_pulses = 0, oe_pulses = 0, start_pulses = 0, rsp_pulses = 0, b_rsp_n = 0;
  logic [8:0]  last_waddr;
  logic [6:0]  last_wsize;
  logic [63:0] last_wdata;
  logic [1:0]  b_last_st;
  logic [63:0] b_last_d;

  // Bus monitor plus slave/core responder, all on the falling edge.
  always @(negedge clock) begin
    sout_rdy   = {1'($urandom), 1'b0};
    sout_rdata = {$urandom, $urandom, $urandom, $urandom};
    done_port  = 1'b0;
    check("bus_oe_we_excl", 64'(a_oe[0] & a_we[0]), 64'd0);
    check("bus_lane1_zero", 64'({a_oe[1], a_we[1], |a_addr[17:9], |a_wdata[127:64], |a_size[13:7]}), 64'd0);
    if (a_we[0]) begin
      we_pulses++;
      last_waddr = a_addr[8:0];
      last_wsize = a_size[6:0];
      last_wdata = a_wdata[63:0];
      mem[a_addr[8:0]] = a_wdata[63:0];
    end
    if (a_oe[0])     oe_pulses++;
    if (a_start)     start_pulses++;
    if (a_rsp_valid) rsp_pulses++;
    if (b_rsp_valid) begin
      b_rsp_n++;
      b_last_st = b_rsp_status;
      b_last_d  = b_rsp_data;
    end
    if (!reset) begin
      rd_cnt = -1;
      done_cnt = -1;
    end else begin
      if (a_oe[0] && resp_lat >= 0) begin
        rd_cnt  = resp_lat;
        rd_addr = a_addr[8:0];
      end
      if (rd_cnt == 0) begin
        sout_rdy[0] = 1'b1;
        sout_rdata[63:0] = mem.exists(rd_addr) ? mem[rd_addr] : 64'h0;
        rd_cnt = -1;
      end else if (rd_cnt > 0) begin
        rd_cnt--;
      end
      if (a_start && done_after >= 0) done_cnt = done_after;
      if (done_cnt == 0) begin
        done_port = 1'b1;
        done_cnt = -1;
      end else if (done_cnt > 0) begin
        done_cnt--;
      end
    end
  end

  task automatic send(input string tag, input logic [1:0] op, input logic [8:0] addr,
                      input logic [6:0] size, input logic [63:0] wdata);
    int guard = 0;
    @(negedge clock);
    while (!(a_ready && b_ready) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    check({tag, "/cmd_ready"}, 64'(a_ready && b_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget, output logic [1:0] st,
                          output logic [63:0] d, output int lat);
    lat = 1;
    while (!a_rsp_valid && lat < budget) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "/rsp_seen"}, 64'(a_rsp_valid), 64'd1);
    st = a_rsp_status;
    d  = a_rsp_data;
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [8:0] addr,
                        input logic [6:0] size, input logic [63:0] wdata);
    logic [1:0]  exp_st, exp_bst, st;
    logic [63:0] exp_d, exp_bd, d, stored;
    int exp_lat, lat, we0, oe0, sp0, bn0;
    we0 = we_pulses; oe0 = oe_pulses; sp0 = start_pulses; bn0 = b_rsp_n;
    stored  = ref_mem.exists(addr) ? ref_mem[addr] : 64'h0;
    exp_st  = 2'd0;
    exp_d   = 64'h0;
    exp_lat = 2;
    if (op == OPR) begin
      if (resp_lat < 0) begin
        exp_st  = 2'd1;
        exp_lat = 2 + RD_TO;
      end else begin
        exp_d   = stored & size_mask(int'(size));
        exp_lat = resp_lat + 2;
      end
    end else if (op == OPN) begin
      exp_d   = 64'(done_after + 1);
      exp_lat = done_after + 2;
    end
    exp_bst = exp_st;
    exp_bd  = exp_d;
    if (op == OPN && done_after + 1 > B_LIMIT) begin
      exp_bst = 2'd2;
      exp_bd  = 64'(B_LIMIT);
    end
    send(tag, op, addr, size, wdata);
    wait_rsp(tag, 400, st, d, lat);
    #1;
    check({tag, "/status"}, 64'(st), 64'(exp_st));
    check({tag, "/data"}, d, exp_d);
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/we_pulses"}, 64'(we_pulses - we0), 64'(op == OPW));
    check({tag, "/oe_pulses"}, 64'(oe_pulses - oe0), 64'(op == OPR));
    check({tag, "/start_pulses"}, 64'(start_pulses - sp0), 64'(op == OPN));
    check({tag, "/lim_rsp_count"}, 64'(b_rsp_n - bn0), 64'd1);
    check({tag, "/lim_status"}, 64'(b_last_st), 64'(exp_bst));
    check({tag, "/lim_data"}, b_last_d, exp_bd);
    if (op == OPW) begin
      check({tag, "/bus_addr"}, 64'(last_waddr), 64'(addr));
      check({tag, "/bus_size"}, 64'(last_wsize), 64'(size));
      check({tag, "/bus_wdata"}, last_wdata, wdata);
      ref_mem[addr] = wdata;
    end
  endtask

  // Pull reset mid-operation and confirm a silent return to IDLE.
  task automatic reset_midway(input string tag);
    int rp0, bn0;
    rp0 = rsp_pulses; bn0 = b_rsp_n;
    reset = 1'b0;
    #1;
    check({tag, "/outs_zero"}, 64'({a_rsp_valid, a_rsp_status, a_start, a_oe, a_we, a_ready,
          |a_addr, |a_wdata, |a_size, |a_rsp_data}), 64'd0);
    check({tag, "/lim_outs_zero"}, 64'({b_rsp_valid, b_start, b_oe, b_we, b_ready}), 64'd0);
    repeat (2) @(negedge clock);
    check({tag, "/ready_in_reset"}, 64'(a_ready), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check({tag, "/ready_after"}, 64'(a_ready && b_ready), 64'd1);
    repeat (3) @(negedge clock);
    #1;
    check({tag, "/no_rsp"}, 64'(rsp_pulses - rp0), 64'd0);
    check({tag, "/lim_no_rsp"}, 64'(b_rsp_n - bn0), 64'd0);
  endtask

  initial begin
    int rp0;
    int k;
    logic [8:0] addr;
    logic [6:0] size;

    repeat (2) @(negedge clock);
    check("reset/outs_zero", 64'({a_rsp_valid, a_rsp_status, a_start, a_oe, a_we, a_ready,
          |a_addr, |a_wdata, |a_size, |a_rsp_data}), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("reset/ready_after", 64'(a_ready), 64'd1);

    // Directed: write then masked read-back of the same location.
    do_cmd("wr_deadbeef", OPW, 9'h010, 7'd32, 64'h0000_0000_DEADBEEF);
    mem[9'h010]     = 64'hFFFF_FFFF_DEADBEEF;
    ref_mem[9'h010] = 64'hFFFF_FFFF_DEADBEEF;
    resp_lat = 2;
    do_cmd("rd_deadbeef", OPR, 9'h010, 7'd32, 64'h0);
    resp_lat = 0;
    do_cmd("rd_same_cycle", OPR, 9'h010, 7'd64, 64'h0);
    resp_lat = -1;
    do_cmd("rd_timeout", OPR, 9'h010, 7'd32, 64'h0);

    // Directed: runs, including done during the start cycle and a run past
    // the 50-cycle limit of the second instance.
    done_after = 100;
    do_cmd("run_100", OPN, 9'h0, 7'd0, 64'h0);
    done_after = 0;
    do_cmd("run_done_at_start", OPN, 9'h0, 7'd0, 64'h0);
    done_after = 49;
    do_cmd("run_done_at_limit", OPN, 9'h0, 7'd0, 64'h0);
    do_cmd("after_limit_wr", OPW, 9'h1FF, 7'd8, 64'h1234_5678_9ABC_DEF0);

    // Reserved opcode is swallowed without a response.
    rp0 = rsp_pulses;
    send("rsvd", OPX, 9'h0, 7'd0, 64'h0);
    repeat (4) @(negedge clock);
    #1;
    check("rsvd/no_rsp", 64'(rsp_pulses - rp0), 64'd0);
    check("rsvd/ready", 64'(a_ready), 64'd1);

    // Reset during RUN and during RD_WAIT.
    done_after = -1;
    send("rst_run", OPN, 9'h0, 7'd0, 64'h0);
    repeat (5) @(negedge clock);
    reset_midway("rst_run");
    resp_lat = -1;
    send("rst_rdwait", OPR, 9'h010, 7'd32, 64'h0);
    repeat (4) @(negedge clock);
    reset_midway("rst_rdwait");

    // Randomized mix against the reference memory and command rules.
    for (int i = 0; i < 40; i++) begin
      k    = int'($urandom_range(0, 9));
      addr = 9'h100 + 9'(8 * $urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       size = 7'd8;
        1:       size = 7'd16;
        2:       size = 7'd32;
        3:       size = 7'd64;
        default: size = 7'($urandom_range(0, 127));
      endcase
      if (k < 4) begin
        do_cmd("rand_wr", OPW, addr, size, {$urandom, $urandom});
      end else if (k < 8) begin
        resp_lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
        do_cmd("rand_rd", OPR, addr, size, 64'h0);
      end else begin
        done_after = int'($urandom_range(0, 60));
        do_cmd("rand_run", OPN, 9'h0, 7'd0, 64'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
